// File: rtl/mul_div_ctrl.sv
// RV32M multiply/divide sequencer: shift-add multiply and restoring divide,
// one bit per clk_100M cycle, holding alu_complete low while an operation runs.
module mul_div_ctrl #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic            clk_100M,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            abort,
  output logic            alu_complete,
  output logic [XLEN-1:0] result,
  output logic            result_valid
);

  localparam int unsigned      AW       = 2 * XLEN;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0]  XMIN     = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PREP   = 3'd1,
    MUL_IT = 3'd2,
    DIV_IT = 3'd3,
    FIXUP  = 3'd4,
    DONE   = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       f3_q, f3_d;
  logic [XLEN-1:0]  a_q, a_d;
  logic [XLEN-1:0]  b_q, b_d;
  logic             neg_a_q, neg_a_d;
  logic             neg_b_q, neg_b_d;
  logic [XLEN-1:0]  opnd_q, opnd_d;
  logic [AW-1:0]    acc_q, acc_d;
  logic             alu_complete_d;
  logic [XLEN-1:0]  result_d;
  logic             result_valid_d;

  logic             sign_a, sign_b, neg_a_c, neg_b_c;
  logic [XLEN-1:0]  abs_a, abs_b;
  logic             div_zero, div_ovf;
  logic [XLEN:0]    mul_sum;
  logic [XLEN:0]    rem_sh, div_diff;
  logic [AW-1:0]    prod;
  logic [XLEN-1:0]  quo_fix, rem_fix;

  // Operand sign handling and per-iteration arithmetic
  always_comb begin
    sign_a   = (f3_q == 3'b001) || (f3_q == 3'b010) || (f3_q == 3'b100) || (f3_q == 3'b110);
    sign_b   = (f3_q == 3'b001) || (f3_q == 3'b100) || (f3_q == 3'b110);
    neg_a_c  = sign_a & a_q[XLEN-1];
    neg_b_c  = sign_b & b_q[XLEN-1];
    abs_a    = neg_a_c ? -a_q : a_q;
    abs_b    = neg_b_c ? -b_q : b_q;
    div_zero = (b_q == '0);
    div_ovf  = !f3_q[0] && (a_q == XMIN) && (b_q == '1);
    mul_sum  = {1'b0, acc_q[AW-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    rem_sh   = acc_q[AW-1:XLEN-1];
    div_diff = rem_sh - {1'b0, opnd_q};
    prod     = (neg_a_q ^ neg_b_q) ? -acc_q : acc_q;
    quo_fix  = (neg_a_q ^ neg_b_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    rem_fix  = neg_a_q ? -acc_q[AW-1:XLEN] : acc_q[AW-1:XLEN];
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    f3_d           = f3_q;
    a_d            = a_q;
    b_d            = b_q;
    neg_a_d        = neg_a_q;
    neg_b_d        = neg_b_q;
    opnd_d         = opnd_q;
    acc_d          = acc_q;
    alu_complete_d = alu_complete;
    result_d       = result;
    result_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          f3_d           = funct3;
          a_d            = op_a;
          b_d            = op_b;
          alu_complete_d = 1'b0;
          state_d        = PREP;
        end
      end
      PREP: begin
        neg_a_d = neg_a_c;
        neg_b_d = neg_b_c;
        cnt_d   = '0;
        if (f3_q[2]) begin
          opnd_d = abs_b;
          acc_d  = {{XLEN{1'b0}}, abs_a};
        end else begin
          opnd_d = abs_a;
          acc_d  = {{XLEN{1'b0}}, abs_b};
        end
        if (f3_q[2] && (div_zero || div_ovf)) begin
          if (div_zero) result_d = f3_q[1] ? a_q : '1;
          else          result_d = f3_q[1] ? '0 : XMIN;
          result_valid_d = 1'b1;
          alu_complete_d = 1'b1;
          state_d        = DONE;
        end else begin
          state_d = f3_q[2] ? DIV_IT : MUL_IT;
        end
      end
      MUL_IT: begin
        acc_d = {mul_sum, acc_q[XLEN-1:1]};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) state_d = FIXUP;
      end
      DIV_IT: begin
        // Non-negative trial difference means the divisor fits: keep it, quotient bit 1
        if (!div_diff[XLEN]) acc_d = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        else                 acc_d = {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) state_d = FIXUP;
      end
      FIXUP: begin
        if (f3_q[2])              result_d = f3_q[1] ? rem_fix : quo_fix;
        else if (f3_q[1:0] == 2'b00) result_d = prod[XLEN-1:0];
        else                      result_d = prod[AW-1:XLEN];
        result_valid_d = 1'b1;
        alu_complete_d = 1'b1;
        state_d        = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d        = IDLE;
        alu_complete_d = 1'b1;
      end
    endcase

    // Abort wins over every other transition outside IDLE
    if (abort && (state_q != IDLE)) begin
      state_d        = IDLE;
      alu_complete_d = 1'b1;
      result_d       = result;
      result_valid_d = 1'b0;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk_100M or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      f3_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      neg_a_q      <= 1'b0;
      neg_b_q      <= 1'b0;
      opnd_q       <= '0;
      acc_q        <= '0;
      alu_complete <= 1'b1;
      result       <= '0;
      result_valid <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      f3_q         <= f3_d;
      a_q          <= a_d;
      b_q          <= b_d;
      neg_a_q      <= neg_a_d;
      neg_b_q      <= neg_b_d;
      opnd_q       <= opnd_d;
      acc_q        <= acc_d;
      alu_complete <= alu_complete_d;
      result       <= result_d;
      result_valid <= result_valid_d;
    end
  end

endmodule

// File: tb/tb_mul_div_ctrl.sv
// Bench for mul_div_ctrl: cycle-level behavioural model compared every cycle,
// directed RV32M cases with literal results, and randomized traffic with aborts.
module tb_mul_div_ctrl;

  logic        clk_100M = 1'b0;
  logic        rst_n    = 1'b0;
  logic        start    = 1'b0;
  logic        abort    = 1'b0;
  logic [2:0]  funct3   = '0;
  logic [31:0] op_a     = '0;
  logic [31:0] op_b     = '0;
  logic        alu_complete;
  logic        result_valid;
  logic [31:0] result;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_100M = ~clk_100M;

  mul_div_ctrl #(.XLEN(32), .CNT_W(6)) dut (
    .clk_100M     (clk_100M),
    .rst_n        (rst_n),
    .start        (start),
    .funct3       (funct3),
    .op_a         (op_a),
    .op_b         (op_b),
    .abort        (abort),
    .alu_complete (alu_complete),
    .result       (result),
    .result_valid (result_valid)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural RV32M result from plain integer arithmetic
  function automatic logic [31:0] ref_res(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, ua, ub;
    logic [63:0] p;
    int          ia, ib;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    ia = int'(a);
    ib = int'(b);
    case (f)
      3'd0: begin p = 64'(ua * ub); return p[31:0];  end
      3'd1: begin p = 64'(sa * sb); return p[63:32]; end
      3'd2: begin p = 64'(sa * ub); return p[63:32]; end
      3'd3: begin p = 64'(ua * ub); return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFFFFFF;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
        return 32'(ia / ib);
      end
      3'd5: return (b == 0) ? 32'hFFFFFFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
        return 32'(ia % ib);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic bit is_special(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    return f[2] && ((b == 0) || (!f[0] && a == 32'h80000000 && b == 32'hFFFFFFFF));
  endfunction

  // Cycle model: busy countdown, one DONE cycle, abort, asynchronous reset
  bit          m_busy     = 1'b0;
  bit          m_valid    = 1'b0;
  bit          m_complete = 1'b1;
  bit          m_prev_valid;
  int          m_left     = 0;
  logic [31:0] m_pending  = '0;
  logic [31:0] m_result   = '0;

  always @(posedge clk_100M or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 0; m_valid = 0; m_complete = 1; m_left = 0; m_result = '0;
    end else begin
      m_prev_valid = m_valid;
      m_valid = 0;
      if (m_prev_valid) begin
        m_busy = 0;
      end else if (!m_busy) begin
        if (start) begin
          m_busy     = 1;
          m_complete = 0;
          m_left     = is_special(funct3, op_a, op_b) ? 1 : 34;
          m_pending  = ref_res(funct3, op_a, op_b);
        end
      end else if (abort) begin
        m_busy = 0; m_complete = 1;
      end else begin
        m_left--;
        if (m_left == 0) begin
          m_busy = 0; m_valid = 1; m_complete = 1; m_result = m_pending;
        end
      end
    end
  end

  always @(negedge clk_100M) begin
    chk("alu_complete", {31'b0, alu_complete}, {31'b0, m_complete});
    chk("result_valid", {31'b0, result_valid}, {31'b0, m_valid});
    chk("result", result, m_result);
  end

  task automatic run_op(input string name, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp);
    int n;
    bit got;
    @(negedge clk_100M);
    funct3 = f; op_a = a; op_b = b; start = 1'b1;
    n = 0; got = 0;
    while (!got && n < 100) begin
      @(negedge clk_100M);
      n++;
      if (result_valid) got = 1;
      else begin
        start = 1'($urandom); funct3 = 3'($urandom); op_a = $urandom; op_b = $urandom;
      end
    end
    start = 1'b0;
    chk({name, " latency"}, 32'(n), is_special(f, a, b) ? 32'd2 : 32'd35);
    chk(name, result, exp);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFFFFFF;
      3: return 32'h80000000;
      4: return 32'h7FFFFFFF;
      5: return 32'($urandom_range(15));
      default: return $urandom;
    endcase
  endfunction

  logic [31:0] held;
  int          pulses;

  initial begin
    repeat (3) @(negedge clk_100M);
    chk("reset alu_complete", {31'b0, alu_complete}, 32'd1);
    chk("reset result_valid", {31'b0, result_valid}, 32'd0);
    chk("reset result", result, 32'h0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk_100M);
    chk("post-reset alu_complete", {31'b0, alu_complete}, 32'd1);
    chk("post-reset result", result, 32'h0);

    chk("pin MUL",    ref_res(3'd0, 32'd7, 32'hFFFFFFFD), 32'hFFFFFFEB);
    chk("pin MULH",   ref_res(3'd1, 32'h80000000, 32'h80000000), 32'h40000000);
    chk("pin MULHU",  ref_res(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF), 32'hFFFFFFFE);
    chk("pin MULHSU", ref_res(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF), 32'hFFFFFFFF);
    chk("pin DIV",    ref_res(3'd4, 32'hFFFFFFF9, 32'd2), 32'hFFFFFFFD);
    chk("pin REM",    ref_res(3'd6, 32'hFFFFFFF9, 32'd2), 32'hFFFFFFFF);

    run_op("MUL",        3'd0, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB);
    run_op("MULH",       3'd1, 32'h80000000, 32'h80000000, 32'h40000000);
    run_op("MULHU",      3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
    run_op("MULHSU",     3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
    run_op("DIV",        3'd4, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD);
    run_op("REM",        3'd6, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF);
    run_op("DIVU",       3'd5, 32'd100, 32'd7, 32'd14);
    run_op("REMU",       3'd7, 32'd100, 32'd7, 32'd2);
    run_op("DIVU by 0",  3'd5, 32'd5, 32'd0, 32'hFFFFFFFF);
    run_op("REM by 0",   3'd6, 32'd5, 32'd0, 32'd5);
    run_op("DIV ovf",    3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000);
    run_op("REM ovf",    3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h0);

    // Abort part-way through a divide
    held = result;
    @(negedge clk_100M);
    funct3 = 3'd4; op_a = 32'd1000; op_b = 32'd3; start = 1'b1;
    @(negedge clk_100M);
    start = 1'b0;
    repeat (10) @(negedge clk_100M);
    abort = 1'b1;
    @(negedge clk_100M);
    abort = 1'b0;
    chk("abort alu_complete", {31'b0, alu_complete}, 32'd1);
    chk("abort result_valid", {31'b0, result_valid}, 32'd0);
    chk("abort result", result, held);
    pulses = 0;
    repeat (40) begin
      @(negedge clk_100M);
      if (result_valid) pulses++;
    end
    chk("abort no pulse", 32'(pulses), 32'd0);
    run_op("MUL after abort", 3'd0, 32'd3, 32'd4, 32'd12);

    // Reset in the middle of a multiply
    @(negedge clk_100M);
    funct3 = 3'd0; op_a = 32'd5; op_b = 32'd6; start = 1'b1;
    @(negedge clk_100M);
    start = 1'b0;
    repeat (10) @(negedge clk_100M);
    #2 rst_n = 1'b0;
    #1;
    chk("mid reset alu_complete", {31'b0, alu_complete}, 32'd1);
    chk("mid reset result_valid", {31'b0, result_valid}, 32'd0);
    chk("mid reset result", result, 32'h0);
    @(negedge clk_100M);
    rst_n = 1'b1;
    pulses = 0;
    repeat (40) begin
      @(negedge clk_100M);
      if (result_valid) pulses++;
    end
    chk("mid reset no pulse", 32'(pulses), 32'd0);

    // Random traffic with corner operands and occasional aborts
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk_100M);
      start  = ($urandom_range(3) == 0);
      abort  = ($urandom_range(99) == 0);
      funct3 = 3'($urandom);
      op_a   = pick();
      op_b   = pick();
    end
    @(negedge clk_100M);
    start = 1'b0;
    abort = 1'b0;
    repeat (40) @(negedge clk_100M);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mul_div_ctrl.md
# mul_div_ctrl

Multi-cycle sequencer for the RV32M multiply/divide unit. It accepts one operation from the control path, runs a fixed-length shift-add multiply or restoring divide, and holds `alu_complete` low while busy. That signal freezes the phase-clock generator, so the rest of the CPU stalls until the result is ready. `clk_100M` clocks the block directly; it uses no derived phase clock.

## Interface
- `XLEN`, default 32: operand and result width.
- `CNT_W`, default 6: iteration counter width; must satisfy 2^CNT_W > XLEN.
- `clk_100M`  in  1: system clock. All state changes on its rising edge.
- `rst_n`  in  1: reset. Asynchronous, active-low.
- `start`  in  1: request. Sampled only in IDLE.
- `funct3`  in  3: RV32M opcode. 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `op_a`  in  XLEN: rs1 value (multiplicand or dividend).
- `op_b`  in  XLEN: rs2 value (multiplier or divisor).
- `abort`  in  1: synchronous kill of the current operation.
- `alu_complete`  out  1: 1 when idle or done; 0 while an operation is in flight.
- `result`  out  XLEN: registered result. Holds its value until the next DONE.
- `result_valid`  out  1: one-cycle pulse when `result` updates.

## Operation
- Reset values: state IDLE, `alu_complete`=1, `result`=0, `result_valid`=0, counter=0. All internal operand and accumulator registers are 0.
- **IDLE**
  - On `start`=1, latch `funct3`, `op_a` and `op_b`.
  - Drive `alu_complete`<=0 and go to PREP.
  - Operands may change after that edge.
- **PREP**
  - Compute sign flags: `op_a` is signed for MULH, MULHSU, DIV and REM; `op_b` is signed for MULH, DIV and REM.
  - Load magnitudes (two's-complement absolute value for signed negative operands) and clear the counter.
  - Special cases (divide ops only) go straight to DONE with the result:
    - divisor 0: DIV/DIVU give all-ones; REM/REMU give the dividend unchanged.
    - DIV with `op_a`=0x80000000 and `op_b`=0xFFFFFFFF gives 0x80000000; REM with the same operands gives 0.
  - Otherwise go to MUL_IT (funct3[2]=0) or DIV_IT (funct3[2]=1).
- **MUL_IT**
  - One iteration per cycle on the 2*XLEN accumulator: if the multiplier LSB is 1, add the multiplicand to the upper half; then shift right by 1.
  - Exactly XLEN iterations; after the last, go to FIXUP.
- **DIV_IT**
  - Restoring division, one quotient bit per cycle.
  - Shift the {remainder, dividend} pair left by 1 and trial-subtract the divisor using XLEN+1 bits.
  - If the difference is non-negative, keep it and set the quotient bit to 1.
  - Exactly XLEN iterations; after the last, go to FIXUP.
- **FIXUP**
  - Multiply: negate the 64-bit product if the two sign flags differ. MUL selects bits [31:0]; the others select [63:32].
  - Divide: negate the quotient if the sign flags differ (DIV). Negate the remainder if the dividend was negative (REM).
  - Register `result` and go to DONE.
- **DONE**
  - `result_valid`=1 and `alu_complete`=1 for exactly this cycle; the next edge returns to IDLE.
  - `start` is ignored in DONE. A new request is accepted from IDLE only.
- **Busy and abort rules**
  - `start` in any non-IDLE state is ignored; there is no queue.
  - `abort`=1 in any non-IDLE state: next edge goes to IDLE with `alu_complete`<=1. `result_valid` is not pulsed and `result` keeps its old value.
  - `abort` outranks `start` and the normal transitions, including when both arrive on the same edge.
- **Width rules**
  - Negation is two's-complement modulo 2^width.
  - abs(0x80000000) = 0x80000000, treated as unsigned. This is exact for every case.
  - Counter wraps are impossible because the terminal count is XLEN-1.

## Timing
- `start` is sampled at edge N; `alu_complete` falls after edge N.
- Normal path: PREP at N+1, iterations at N+2..N+33, FIXUP at N+34. State is DONE during the cycle after N+34, with `result_valid` high and `alu_complete` back to 1.
- Fixed latency is 35 edges from sampling `start` to `result_valid`, independent of operand values.
- Special-case path: DONE follows edge N+1, so `result_valid` is high in the cycle after N+1 (2 edges).
- Earliest back-to-back `start` is the cycle after DONE, which is IDLE.
- Reset mid-operation: all outputs take their reset values immediately (asynchronous) and the operation is lost.

## Test plan
- Reset with `start`=0: `alu_complete`=1, `result`=0, `result_valid`=0. Release reset; outputs stay unchanged.
- MUL 7 × 0xFFFFFFFD → `result`=0xFFFFFFEB, pulse 35 edges after `start`, `alu_complete` low the whole time in between. Repeat MULH 0x80000000 × 0x80000000 → 0x40000000, MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE, and MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 → 0xFFFFFFFD. REM with the same operands → 0xFFFFFFFF. DIVU 100 / 7 → 14. REMU 100 / 7 → 2.
- Special cases, each pulsing after 2 edges:
  - DIVU 5 / 0 → 0xFFFFFFFF.
  - REM 5 / 0 → 5.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000.
  - REM 0x80000000 / 0xFFFFFFFF → 0.
- Assert `abort` at iteration 10 of a DIV: `alu_complete`=1 on the next cycle, no `result_valid`, `result` unchanged. Then a new MUL 3 × 4 → 12 runs normally.
- Toggle `start` and operands mid-operation: the result is unaffected. Deassert `rst_n` mid-operation: outputs reset immediately and no pulse follows.
